// File: rtl/octree_bfs_engine.sv
// Breadth-first octree walker: pops node addresses from a circular queue, reads each node
// word, emits one visited-node record per node and queues its nonzero children.
module octree_bfs_engine #(
    parameter int PTR_W     = 16,
    parameter int NUM_CHILD = 8,
    parameter int META_W    = 24,
    parameter int Q_DEPTH   = 16,
    parameter int MEM_LAT   = 1,
    parameter int MAX_LEVEL = 7,
    localparam int LVL_W    = (MAX_LEVEL < 1) ? 1 : $clog2(MAX_LEVEL + 1)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [PTR_W-1:0]                i_root_addr,
    output logic                            o_enb,
    output logic [PTR_W-1:0]                o_addrb,
    input  logic [NUM_CHILD*PTR_W+META_W-1:0] i_doutb,
    output logic                            o_node_valid,
    input  logic                            i_node_ready,
    output logic [PTR_W-1:0]                o_node_addr,
    output logic [LVL_W-1:0]                o_node_level,
    output logic [META_W-1:0]               o_node_meta,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_overflow
);
    localparam int QA_W   = $clog2(Q_DEPTH);
    localparam int CNT_W  = QA_W + 1;
    localparam int WC_W   = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
    localparam int K_W    = (NUM_CHILD < 2) ? 1 : $clog2(NUM_CHILD);
    localparam int WORD_W = NUM_CHILD * PTR_W + META_W;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_PUSH, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [PTR_W-1:0]   r_q_addr [Q_DEPTH];
    logic [LVL_W-1:0]   r_q_lvl  [Q_DEPTH];
    logic [QA_W-1:0]    r_head, r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [WC_W-1:0]    r_wait;
    logic [K_W-1:0]     r_k;
    logic [PTR_W-1:0]   r_cur_addr;
    logic [LVL_W-1:0]   r_cur_lvl;
    logic [WORD_W-1:0]  r_word;
    logic               r_overflow;

    logic               w_pop, w_push, w_full;
    logic [PTR_W-1:0]   w_push_addr;
    logic [LVL_W-1:0]   w_push_lvl;
    logic [PTR_W-1:0]   w_children [NUM_CHILD];

    for (genvar k = 0; k < NUM_CHILD; k++) begin : g_child
        assign w_children[k] = r_word[META_W + k*PTR_W +: PTR_W];
    end

    assign w_full       = (r_count == CNT_W'(Q_DEPTH));
    assign o_node_addr  = r_cur_addr;
    assign o_node_level = r_cur_lvl;
    assign o_node_meta  = r_word[META_W-1:0];
    assign o_overflow   = r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_enb        = 1'b0;
        o_addrb      = '0;
        o_node_valid = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_push_addr  = '0;
        w_push_lvl   = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_push      = 1'b1;
                    w_push_addr = i_root_addr;
                    w_next      = S_FETCH;
                end
            end
            S_FETCH: begin
                o_busy = 1'b1;
                if (r_count == '0) begin
                    w_next = S_DONE;
                end else begin
                    w_pop   = 1'b1;
                    o_enb   = 1'b1;
                    o_addrb = r_q_addr[r_head];
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (r_wait == '0) w_next = S_EMIT;
            end
            S_EMIT: begin
                o_busy       = 1'b1;
                o_node_valid = 1'b1;
                if (i_node_ready) w_next = S_PUSH;
            end
            S_PUSH: begin
                o_busy = 1'b1;
                // Leaves at the depth limit still burn the full child-scan time.
                if (r_cur_lvl != LVL_W'(MAX_LEVEL) && w_children[r_k] != '0) begin
                    w_push      = 1'b1;
                    w_push_addr = w_children[r_k];
                    w_push_lvl  = r_cur_lvl + 1'b1;
                end
                if (r_k == K_W'(NUM_CHILD - 1)) w_next = S_FETCH;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !w_full) begin
            r_q_addr[r_tail] <= w_push_addr;
            r_q_lvl[r_tail]  <= w_push_lvl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_wait     <= '0;
            r_k        <= '0;
            r_cur_addr <= '0;
            r_cur_lvl  <= '0;
            r_word     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) r_overflow <= 1'b0;
            if (w_push) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_tail  <= r_tail + 1'b1;
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_pop) begin
                r_cur_addr <= r_q_addr[r_head];
                r_cur_lvl  <= r_q_lvl[r_head];
                r_head     <= r_head + 1'b1;
                r_count    <= r_count - 1'b1;
                r_wait     <= WC_W'(MEM_LAT - 1);
                r_k        <= '0;
            end
            if (r_state == S_WAIT) begin
                if (r_wait == '0) r_word <= i_doutb;
                else              r_wait <= r_wait - 1'b1;
            end
            if (r_state == S_PUSH) r_k <= r_k + 1'b1;
        end
    end
endmodule

// File: tb/tb_octree_bfs_engine.sv
// Bench for octree_bfs_engine: two instances (default, and small queue / shallow depth / slower
// memory) are driven with fixed and random trees; a BFS reference model fills the scoreboards.
module tb_octree_bfs_engine;
    localparam int PW = 16;
    localparam int NC = 8;
    localparam int MW = 24;
    localparam int WW = NC * PW + MW;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  lvl;
        logic [23:0] meta;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start_a, start_b, rmode, dir_rdy, rnd_a, rnd_b;
    logic [15:0]   root_a, root_b;
    logic          enb_a, v_a, busy_a, done_a, ovf_a, rdy_a;
    logic          enb_b, v_b, busy_b, done_b, ovf_b, rdy_b;
    logic [15:0]   addrb_a, naddr_a, addrb_b, naddr_b;
    logic [2:0]    nlvl_a;
    logic [0:0]    nlvl_b;
    logic [23:0]   meta_a, meta_b;
    logic [WW-1:0] dout_a, dout_b, d1_b;
    logic [WW-1:0] mem [256];

    assign rdy_a = rmode ? rnd_a : dir_rdy;
    assign rdy_b = rmode ? rnd_b : dir_rdy;

    octree_bfs_engine dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_root_addr(root_a),
        .o_enb(enb_a), .o_addrb(addrb_a), .i_doutb(dout_a),
        .o_node_valid(v_a), .i_node_ready(rdy_a), .o_node_addr(naddr_a),
        .o_node_level(nlvl_a), .o_node_meta(meta_a), .o_busy(busy_a),
        .o_done(done_a), .o_overflow(ovf_a)
    );

    octree_bfs_engine #(.Q_DEPTH(4), .MEM_LAT(2), .MAX_LEVEL(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_root_addr(root_b),
        .o_enb(enb_b), .o_addrb(addrb_b), .i_doutb(dout_b),
        .o_node_valid(v_b), .i_node_ready(rdy_b), .o_node_addr(naddr_b),
        .o_node_level(nlvl_b), .o_node_meta(meta_b), .o_busy(busy_b),
        .o_done(done_b), .o_overflow(ovf_b)
    );

    // Node memories: one-cycle read for A, two-cycle pipelined read for B.
    always @(posedge clk) if (enb_a) dout_a <= mem[addrb_a[7:0]];
    always @(posedge clk) begin
        d1_b   <= enb_b ? mem[addrb_b[7:0]] : '0;
        dout_b <= d1_b;
    end

    rec_t exp_a[$], exp_b[$], mdl_out[$];
    bit   mdl_ovf;
    bit   fetched_a[256], fetched_b[256];
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] child_of(input logic [15:0] a, input int k);
        return mem[a[7:0]][MW + k*PW +: PW];
    endfunction

    task automatic set_child(input logic [15:0] a, input int k, input logic [15:0] c);
        mem[a[7:0]][MW + k*PW +: PW] = c;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Plain BFS over the memory image with a bounded queue and depth limit.
    task automatic model(input logic [15:0] root, input int qd, input int maxl);
        rec_t q[$];
        rec_t n;
        logic [15:0] c;
        mdl_out.delete();
        mdl_ovf = 1'b0;
        q.push_back('{addr: root, lvl: 4'd0, meta: 24'd0});
        while (q.size() > 0) begin
            n = q.pop_front();
            n.meta = mem[n.addr[7:0]][23:0];
            mdl_out.push_back(n);
            if (int'(n.lvl) < maxl) begin
                for (int k = 0; k < NC; k++) begin
                    c = child_of(n.addr, k);
                    if (c != 16'd0) begin
                        if (q.size() < qd) q.push_back('{addr: c, lvl: n.lvl + 4'd1, meta: 24'd0});
                        else mdl_ovf = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic mon_loop();
        rec_t e;
        forever begin
            @(negedge clk);
            if (v_a && rdy_a) begin
                if (exp_a.size() == 0) begin
                    n_chk++;
                    $display("FAIL rec_a: unexpected record addr %0h level %0d", naddr_a, nlvl_a);
                end else begin
                    e = exp_a.pop_front();
                    chk("rec_a", {naddr_a, 1'b0, nlvl_a, meta_a}, e);
                end
            end
            if (v_b && rdy_b) begin
                if (exp_b.size() == 0) begin
                    n_chk++;
                    $display("FAIL rec_b: unexpected record addr %0h level %0d", naddr_b, nlvl_b);
                end else begin
                    e = exp_b.pop_front();
                    chk("rec_b", {naddr_b, 3'b000, nlvl_b, meta_b}, e);
                end
            end
            if (enb_a) fetched_a[addrb_a[7:0]] = 1'b1;
            if (enb_b) fetched_b[addrb_b[7:0]] = 1'b1;
        end
    endtask

    task automatic build_ref();
        clear_mem();
        set_child(16'd0, 0, 16'd7);
        set_child(16'd0, 4, 16'd3);
        set_child(16'd7, 7, 16'd8);
        set_child(16'd3, 3, 16'd6);
        mem[0][23:0] = 24'h111111;
        mem[7][23:0] = 24'h777777;
        mem[3][23:0] = 24'h333333;
    endtask

    task automatic build_random(input int nnodes, output logic [15:0] root);
        int pool[$];
        logic [15:0] nodes[$];
        int idx, j, t;
        clear_mem();
        for (int i = 1; i < 256; i++) pool.push_back(i);
        for (int i = pool.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = pool[i]; pool[i] = pool[j]; pool[j] = t;
        end
        root = 16'(pool[0]);
        nodes.push_back(root);
        idx = 1;
        for (int p = 0; p < nodes.size() && idx < nnodes; p++)
            for (int k = 0; k < NC; k++)
                if ($urandom_range(0, 2) == 0 && idx < nnodes) begin
                    set_child(nodes[p], k, 16'(pool[idx]));
                    nodes.push_back(16'(pool[idx]));
                    idx++;
                end
        foreach (nodes[i]) mem[nodes[i][7:0]][23:0] = 24'($urandom);
    endtask

    task automatic run(input bit b, input logic [15:0] root, input int hold,
                       input bit rand_rdy, input bit chk_lat, input bit mid_start);
        int qd, maxl, lat, cnt, nrec;
        bit got, found;
        qd   = b ? 4 : 16;
        maxl = b ? 1 : 7;
        lat  = b ? 2 : 1;
        model(root, qd, maxl);
        nrec = mdl_out.size();
        foreach (mdl_out[i]) begin
            if (b) exp_b.push_back(mdl_out[i]);
            else   exp_a.push_back(mdl_out[i]);
        end
        for (int i = 0; i < 256; i++) begin
            fetched_a[i] = 1'b0;
            fetched_b[i] = 1'b0;
        end
        rmode   = rand_rdy;
        dir_rdy = (hold > 0) ? 1'b0 : 1'b1;
        if (b) begin start_b = 1'b1; root_b = root; end
        else   begin start_a = 1'b1; root_a = root; end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        if (hold > 0) begin
            found = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (b ? v_b : v_a) begin found = 1'b1; break; end
                tick();
            end
            chk("hold_seen", 64'(found), 64'd1);
            if (found) begin
                for (int i = 0; i <= hold; i++) begin
                    if (i == hold) dir_rdy = 1'b1;
                    if (b) chk("hold_rec", {v_b, naddr_b, 3'b000, nlvl_b, meta_b}, {1'b1, mdl_out[0]});
                    else   chk("hold_rec", {v_a, naddr_a, 1'b0, nlvl_a, meta_a}, {1'b1, mdl_out[0]});
                    if (i < hold) tick();
                end
            end
        end
        got = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 3000; i++) begin
            tick();
            if (b ? done_b : done_a) begin got = 1'b1; cnt = i; break; end
            if (mid_start && i == 20) begin
                if (b) begin start_b = 1'b1; root_b = 16'd7; end
                else   begin start_a = 1'b1; root_a = 16'd7; end
            end
            if (i == 21) begin start_a = 1'b0; start_b = 1'b0; end
        end
        chk("done_seen", 64'(got), 64'd1);
        if (chk_lat) chk("latency", 64'(cnt), 64'(nrec * (2 + lat + NC) + 1));
        chk("busy_at_done", 64'(b ? busy_b : busy_a), 64'd0);
        chk("overflow", 64'(b ? ovf_b : ovf_a), 64'(mdl_ovf));
        chk("recs_left", 64'(b ? exp_b.size() : exp_a.size()), 64'd0);
        tick();
        chk("done_pulse", 64'(b ? done_b : done_a), 64'd0);
        exp_a.delete();
        exp_b.delete();
        rmode = 1'b0;
        dir_rdy = 1'b1;
    endtask

    task automatic stim();
        logic [15:0] r;
        bit found;
        repeat (3) tick();
        chk("reset_a", {enb_a, addrb_a, v_a, naddr_a, nlvl_a, meta_a, busy_a, done_a, ovf_a}, 64'd0);
        chk("reset_b", {enb_b, addrb_b, v_b, naddr_b, nlvl_b, meta_b, busy_b, done_b, ovf_b}, 64'd0);
        rst = 1'b0;
        tick();

        build_ref();
        run(1'b0, 16'd0, 0, 1'b0, 1'b1, 1'b0);
        run(1'b0, 16'd0, 5, 1'b0, 1'b0, 1'b0);

        // Reset while node 7 is being read, then restart with a stray start mid-run.
        model(16'd0, 16, 7);
        foreach (mdl_out[i]) exp_a.push_back(mdl_out[i]);
        start_a = 1'b1; root_a = 16'd0;
        tick();
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (enb_a && addrb_a == 16'd7) begin found = 1'b1; break; end
        end
        chk("fetch7_seen", 64'(found), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("midreset_a", {enb_a, addrb_a, v_a, naddr_a, nlvl_a, meta_a, busy_a, done_a, ovf_a}, 64'd0);
        exp_a.delete();
        rst = 1'b0;
        tick();
        run(1'b0, 16'd0, 0, 1'b0, 1'b1, 1'b1);

        clear_mem();
        for (int k = 0; k < NC; k++) begin
            set_child(16'd0, k, 16'(k + 1));
            mem[k + 1][23:0] = 24'(32'h100 * (k + 1) + k);
        end
        mem[0][23:0] = 24'hABCDEF;
        run(1'b1, 16'd0, 0, 1'b0, 1'b1, 1'b0);

        build_ref();
        run(1'b1, 16'd0, 0, 1'b0, 1'b1, 1'b0);
        chk("no_fetch_8", 64'(fetched_b[8]), 64'd0);
        chk("no_fetch_6", 64'(fetched_b[6]), 64'd0);

        for (int it = 0; it < 10; it++) begin
            build_random($urandom_range(3, 30), r);
            run(it[0], r, 0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rnd_a = 1'b1;
        rnd_b = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_a = 1'($urandom_range(0, 1));
            rnd_b = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        root_a = '0; root_b = '0;
        rmode = 1'b0; dir_rdy = 1'b1;
        clear_mem();
        fork
            mon_loop();
            stim();
        join_any
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/octree_bfs_engine.md
OCTREE_BFS_ENGINE -- requirements
Module: octree_bfs_engine

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- PTR_W, 16: node address / child pointer width.
- NUM_CHILD, 8: child pointers per node.
- META_W, 24: per-node metadata width at the node-word LSBs.
- Q_DEPTH, 16: BFS queue entries (power of 2).
- MEM_LAT, 1: node-memory read latency in cycles (≥1).
- MAX_LEVEL, 7: deepest level expanded; LVL_W = clog2(MAX_LEVEL+1).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports, one per line (name, direction, width, meaning):
- i_clk, in, 1: clock.
- i_rst, in, 1: sync active-high reset.
- i_start, in, 1: start traversal.
- i_root_addr, in, PTR_W: root node address.
- o_enb, out, 1: node-memory read enable.
- o_addrb, out, PTR_W: node-memory read address.
- i_doutb, in, NUM_CHILD*PTR_W+META_W: node word.
- o_node_valid, out, 1: visited-node record valid.
- i_node_ready, in, 1: consumer accepts record.
- o_node_addr, out, PTR_W: visited node address.
- o_node_level, out, LVL_W: visited node depth.
- o_node_meta, out, META_W: i_doutb[META_W-1:0].
- o_busy, out, 1: traversal in progress.
- o_done, out, 1: one-cycle completion pulse.
- o_overflow, out, 1: sticky, child dropped because the queue was full.

Function
REQ-004 Child k SHALL be i_doutb[META_W+k*PTR_W +: PTR_W]; pointer value 0 means no child.
REQ-005 FSM states SHALL be IDLE, FETCH, WAIT, EMIT, PUSH, DONE.
REQ-006 IDLE: when i_start=1, enqueue (i_root_addr, level 0), set o_busy=1, clear o_overflow, go to FETCH. i_start SHALL be ignored in every other state.
REQ-007 FETCH: if the queue is empty, go to DONE. Otherwise pop the head, drive o_enb=1 and o_addrb=head address for exactly one cycle, then go to WAIT.
REQ-008 WAIT: hold for MEM_LAT cycles, capture i_doutb on the last WAIT cycle, then go to EMIT.
REQ-009 EMIT: assert o_node_valid with addr/level/meta stable until the cycle i_node_ready=1; go to PUSH on the next edge. Records SHALL appear in strict BFS order.
REQ-010 PUSH: take one child per cycle for k=0..NUM_CHILD-1 (NUM_CHILD cycles), then return to FETCH.
- Push nonzero children with level+1.
- If the node level equals MAX_LEVEL, push nothing but still spend the cycles.
REQ-011 Queue is a circular FIFO of {PTR_W address, LVL_W level}. Pointers wrap modulo Q_DEPTH. Count range is 0..Q_DEPTH.
REQ-012 A push while count=Q_DEPTH SHALL drop the child and set o_overflow=1. The flag stays set until the next accepted start or reset; traversal continues.
REQ-013 No simultaneous push and pop occurs: pops happen only in FETCH, pushes only in PUSH/IDLE.
REQ-014 DONE: o_done=1 for exactly one cycle, o_busy=0, then go to IDLE.
REQ-015 Cycle-detection / visited marking is not performed; tree-structured input is required.
REQ-016 Per-node latency SHALL be 1+MEM_LAT+(EMIT cycles)+NUM_CHILD.

Reset
REQ-017 On i_rst=1 at any edge, including mid-traversal, reset SHALL dominate i_start:
- state=IDLE; queue emptied (pointers, count=0).
- o_enb=0, o_addrb=0.
- o_node_valid=0, o_node_addr=0, o_node_level=0, o_node_meta=0.
- o_busy=0, o_done=0, o_overflow=0.

Verification
REQ-018 Defaults; node memory: node0 child0=7, child4=3; node7 child7=8; node3 child3=6; nodes 8, 6 all-zero. Start root 0, ready=1 -> records (addr,level) = (0,0),(7,1),(3,1),(8,2),(6,2), then one o_done pulse, o_overflow=0.
REQ-019 Same tree, i_node_ready low 5 cycles during the first EMIT -> record (0,0) held stable 6 cycles; later sequence unchanged.
REQ-020 Q_DEPTH=4; root with all 8 children nonzero leaves -> first 4 children (k=0..3) visited, o_overflow=1 from the 5th push, o_done pulses.
REQ-021 MAX_LEVEL=1 on REQ-018 tree -> records (0,0),(7,1),(3,1) only; nodes 8 and 6 never fetched (no o_enb at addr 8 or 6).
REQ-022 Assert i_rst during WAIT of node 7 -> next edge all outputs 0, IDLE. A restart re-runs the REQ-018 sequence from (0,0). i_start while busy has no effect.
